// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding, frame width and seven-segment glyph table
package seg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} seg_state_e;
  localparam int FRAME_W = 64;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: nibble to active-low {dp,g..a} byte; SEG_HEX_DECODE_EN enables glyphs for 10-15
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       le,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [6:0] glyph;
`ifdef SEG_HEX_DECODE_EN
  assign glyph = SEG_GLYPH[nibble][6:0];
`else
  assign glyph = nibble > 4'd9 ? SEG_BLANK[6:0] : SEG_GLYPH[nibble][6:0];
`endif
  assign seg = {~dp, le ? glyph : SEG_BLANK[6:0]};
endmodule

// File: rtl/seg_frame_shifter.sv
// seg_frame_shifter: latches digits, decodes a 64-bit segment frame and shifts it MSB-first to the chain (SEG_HEX_DECODE_EN selects hex glyphs)
module seg_frame_shifter
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   le,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    busy,
  output logic                    done,
  output logic                    seg_clk,
  output logic                    seg_dt,
  output logic                    seg_en,
  output logic                    seg_clr,
  output logic [FRAME_W-1:0]      seg_frame
);
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam logic [DW-1:0] P_HI  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] P_END = DW'(2 * CLK_DIV - 1);
  seg_state_e state;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0] le_q, dp_q;
  logic [FRAME_W-1:0] dec;
  logic [5:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg_glyph_decode u_dec (
      .nibble(dig_q[4*i+:4]),
      .le    (le_q[i]),
      .dp    (dp_q[i]),
      .seg   (dec[8*i+:8])
    );
  end
  // transfer sequencer: every output is registered; div_cnt/bit_cnt describe the current cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      dig_q     <= '0;
      le_q      <= '0;
      dp_q      <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_dt    <= 1'b0;
      seg_en    <= 1'b0;
      seg_clr   <= 1'b0;
      seg_frame <= '0;
    end else begin
      seg_clr <= 1'b1;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dig_q <= digits;
          le_q  <= le;
          dp_q  <= dp;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          seg_frame <= dec;
          seg_dt    <= dec[FRAME_W-1];
          seg_clk   <= 1'b0;
          bit_cnt   <= 6'd63;
          div_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: if (div_cnt == P_END) begin
          div_cnt <= '0;
          seg_clk <= 1'b0;
          if (bit_cnt == 6'd0) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            seg_en <= 1'b1;
            state  <= DONE;
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
            seg_dt  <= seg_frame[bit_cnt-6'd1];
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == P_HI) seg_clk <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seg_frame_shifter.sv
// tb_seg_frame_shifter: three divider settings run in lockstep against a cycle-level reference model
module tb_seg_frame_shifter;
  localparam int DIV [3] = '{2, 1, 5};
  localparam int NCYC = 2 + 128 * 5 + 2;
  localparam logic [7:0] GL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
`ifdef SEG_HEX_DECODE_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0] le = '0, dp = '0;
  logic [2:0] busy_w, done_w, sclk_w, sdt_w, en_w, clr_w;
  logic [2:0][63:0] frame_w;
  int compared = 0, mismatched = 0;
  logic [63:0] cap [3];
  int err [3];
  int done_n [3];
  int done_cyc [3];
  logic [63:0] last_exp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    seg_frame_shifter #(.CLK_DIV(DIV[g]), .NUM_DIGITS(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .digits   (digits),
      .le       (le),
      .dp       (dp),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .seg_clk  (sclk_w[g]),
      .seg_dt   (sdt_w[g]),
      .seg_en   (en_w[g]),
      .seg_clr  (clr_w[g]),
      .seg_frame(frame_w[g])
    );
  end

  function automatic logic [63:0] model(input logic [31:0] d, input logic [7:0] l, input logic [7:0] p);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] n;
      logic [7:0] gl;
      n  = d[4*i+:4];
      gl = (n > 4'd9 && !HEX) ? 8'hFF : GL[n];
      f[8*i+:8] = {~p[i], l[i] ? gl[6:0] : 7'h7F};
    end
    return f;
  endfunction

  task automatic run_frame(input logic [31:0] d, input logic [7:0] l, input logic [7:0] p, input int pulse_at);
    logic [63:0] exp;
    logic [2:0] prev;
    exp = model(d, l, p);
    last_exp = exp;
    for (int g = 0; g < 3; g++) begin
      cap[g] = '0; err[g] = 0; done_n[g] = 0; done_cyc[g] = -1;
    end
    @(negedge clk);
    digits = d; le = l; dp = p; start = 1'b1;
    prev = sclk_w;
    @(posedge clk);
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; digits = $urandom; le = 8'($urandom); dp = 8'($urandom);
      end
      if (c == pulse_at) start = 1'b1;
      if (c == pulse_at + 1) start = 1'b0;
      for (int g = 0; g < 3; g++) begin
        int dv, last;
        logic eb, ed, ec, edt;
        dv   = DIV[g];
        last = 2 + 128 * dv;
        eb   = c < last;
        ed   = c == last;
        ec   = c >= 2 && c < last && ((c - 2) % (2 * dv)) >= dv;
        edt  = (c >= 2 && c < last) ? exp[63-(c-2)/(2*dv)] : exp[0];
        if (busy_w[g] !== eb || done_w[g] !== ed || sclk_w[g] !== ec || (c >= 2 && sdt_w[g] !== edt))
          err[g]++;
        if (sclk_w[g] === 1'b1 && prev[g] === 1'b0) cap[g] = {cap[g][62:0], sdt_w[g]};
        if (done_w[g] === 1'b1) begin
          done_n[g]++;
          if (done_cyc[g] < 0) done_cyc[g] = c;
        end
      end
      prev = sclk_w;
    end
    for (int g = 0; g < 3; g++) begin
      compared++;
      if (frame_w[g] !== exp) begin
        mismatched++; $display("FAIL frame[div=%0d] got %h want %h", DIV[g], frame_w[g], exp);
      end
      compared++;
      if (cap[g] !== exp) begin
        mismatched++; $display("FAIL serial[div=%0d] got %h want %h", DIV[g], cap[g], exp);
      end
      compared++;
      if (err[g] !== 0) begin
        mismatched++; $display("FAIL timeline[div=%0d] got %0d bad cycles want 0", DIV[g], err[g]);
      end
      compared++;
      if (done_n[g] !== 1) begin
        mismatched++; $display("FAIL done_count[div=%0d] got %0d want 1", DIV[g], done_n[g]);
      end
      compared++;
      if (done_cyc[g] !== 2 + 128 * DIV[g]) begin
        mismatched++; $display("FAIL done_cycle[div=%0d] got %0d want %0d", DIV[g], done_cyc[g], 2 + 128 * DIV[g]);
      end
      compared++;
      if (en_w[g] !== 1'b1) begin
        mismatched++; $display("FAIL seg_en[div=%0d] got %b want 1", DIV[g], en_w[g]);
      end
    end
  endtask

  task automatic check_all_reset(input string tag);
    for (int g = 0; g < 3; g++) begin
      compared++;
      if ({busy_w[g], done_w[g], sclk_w[g], sdt_w[g], en_w[g], clr_w[g], frame_w[g]} !== 70'b0) begin
        mismatched++;
        $display("FAIL %s[div=%0d] got busy=%b done=%b clk=%b dt=%b en=%b clr=%b frame=%h want all 0",
                 tag, DIV[g], busy_w[g], done_w[g], sclk_w[g], sdt_w[g], en_w[g], clr_w[g], frame_w[g]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    check_all_reset("reset_values");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (clr_w !== 3'b111 || en_w !== 3'b000 || busy_w !== 3'b000) begin
      mismatched++; $display("FAIL after_release got clr=%b en=%b busy=%b want 111/000/000", clr_w, en_w, busy_w);
    end
  endtask

  task automatic test_basic;
    run_frame(32'h00123059, 8'h3F, 8'h00, 0);
    compared++;
    if (frame_w[0] !== 64'hFFFF_F9A4_B0C0_9290) begin
      mismatched++; $display("FAIL basic_const got %h want ffff f9a4 b0c0 9290", frame_w[0]);
    end
  endtask

  task automatic test_dp;
    run_frame(32'h00123059, 8'h3F, 8'h14, 0);
    compared++;
    if (frame_w[0][23] !== 1'b0 || frame_w[0][39] !== 1'b0 || frame_w[0][31] !== 1'b1) begin
      mismatched++; $display("FAIL dp_bits got b23=%b b31=%b b39=%b want 0/1/0", frame_w[0][23], frame_w[0][31], frame_w[0][39]);
    end
  endtask

  task automatic test_hex;
    logic [47:0] want;
    want = HEX ? 48'h8883_C6A1_868E : 48'hFFFF_FFFF_FFFF;
    run_frame(32'hABCDEF00, 8'hFF, 8'h00, 0);
    compared++;
    if (frame_w[0][63:16] !== want || frame_w[0][15:0] !== 16'hC0C0) begin
      mismatched++; $display("FAIL hex_glyphs got %h want %h_c0c0", frame_w[0], want);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) run_frame($urandom, 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_ignored_start;
    run_frame(32'h98765432, 8'hF0, 8'h81, 50);
  endtask

  task automatic test_reset_midshift;
    @(negedge clk);
    digits = $urandom; le = 8'hFF; dp = 8'($urandom); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_all_reset("midshift_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame($urandom, 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_back_to_back;
    int d1, d2, b259, c;
    d1 = -1; d2 = -1; b259 = -1;
    @(negedge clk);
    digits = 32'h01234567; le = 8'hFF; dp = 8'h00; start = 1'b1;
    @(posedge clk);
    for (c = 1; c <= 520; c++) begin
      @(negedge clk);
      if (c == 259) b259 = int'(busy_w[0]);
      if (done_w[0] === 1'b1) begin
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
    end
    start = 1'b0;
    compared++;
    if (d1 !== 258 || d2 !== 517) begin
      mismatched++; $display("FAIL back_to_back_done got %0d,%0d want 258,517", d1, d2);
    end
    compared++;
    if (b259 !== 0) begin
      mismatched++; $display("FAIL back_to_back_gap busy got %0d want 0", b259);
    end
    c = 0;
    while (busy_w !== 3'b000 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    compared++;
    if (busy_w !== 3'b000) begin
      mismatched++; $display("FAIL drain_timeout busy got %b want 000", busy_w);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_dp;
    test_hex;
    test_random;
    test_ignored_start;
    test_reset_midshift;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
